// File: rtl/rom_scan_reader_pkg.sv
// Shared types and constants for the ROM scan reader.
package rom_scan_reader_pkg;

   localparam int unsigned ROM_DEPTH  = 8;
   localparam int unsigned ROM_DATA_W = 4;
   localparam int unsigned ROM_ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_e;

   // Advance a table pointer by one, wrapping at depth.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/rom_scan_reader.sv
// Walks a wrapping address window of a combinational ROM and streams the words out.
// Optional running sum of accepted words: define ROM_SCAN_SUM_EN.
module rom_scan_reader
   import rom_scan_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = ROM_ADDR_W,
   parameter int unsigned DATA_W = ROM_DATA_W,
   parameter int unsigned DEPTH  = ROM_DEPTH,
   parameter int unsigned LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic [LEN_W-1:0]  out_idx,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
`ifdef ROM_SCAN_SUM_EN
   ,
   output logic [DATA_W+LEN_W-1:0] sum
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SUM_W = DATA_W + LEN_W;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    tgt_q, tgt_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [LEN_W-1:0]    out_idx_q, out_idx_d;
   logic                out_valid_q, out_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
`ifdef ROM_SCAN_SUM_EN
   logic [SUM_W-1:0]    sum_q, sum_d;
`endif

   logic [LEN_W-1:0]    len_clamp;
   logic [LEN_W-1:0]    cnt_inc;
   logic                hs;

   assign len_clamp = (32'(len) > DEPTH) ? LEN_W'(DEPTH) : len;
   assign cnt_inc   = cnt_q + LEN_W'(1);
   assign hs        = (state_q == HOLD) && out_valid_q && out_ready;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         tgt_q       <= '0;
         rom_addr_q  <= '0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef ROM_SCAN_SUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         rom_addr_q  <= rom_addr_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef ROM_SCAN_SUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = (len_clamp == '0) ? DONE : READ;
         READ: state_d = HOLD;
         HOLD: if (hs) state_d = (cnt_inc == tgt_q) ? DONE : READ;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and registered-output next values.
   always_comb begin
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      tgt_d       = tgt_q;
      rom_addr_d  = rom_addr_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
`ifdef ROM_SCAN_SUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d      = PTR_W'(32'(base) % DEPTH);
               tgt_d      = len_clamp;
               cnt_d      = '0;
               rom_addr_d = ADDR_W'(ptr_d);
`ifdef ROM_SCAN_SUM_EN
               sum_d      = '0;
`endif
            end
         end
         READ: begin
            out_data_d  = rom_data;
            out_idx_d   = cnt_q;
            out_valid_d = 1'b1;
         end
         HOLD: begin
            if (hs) begin
               out_valid_d = 1'b0;
               cnt_d       = cnt_inc;
               ptr_d       = PTR_W'(ptr_inc(32'(ptr_q), DEPTH));
               rom_addr_d  = ADDR_W'(ptr_d);
`ifdef ROM_SCAN_SUM_EN
               sum_d       = sum_q + SUM_W'(out_data_q);
`endif
            end
         end
         default: ;
      endcase
   end

   assign rom_addr  = rom_addr_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef ROM_SCAN_SUM_EN
   assign sum       = sum_q;
`endif

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: table of scans, hand-written stall/reset sequences, random scans.
module tb_rom_scan_reader;
   import rom_scan_reader_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, start, out_ready, out_valid, busy, done;
   logic [7:0] base, rom_addr;
   logic [3:0] len, rom_data, out_data, out_idx;
`ifdef ROM_SCAN_SUM_EN
   logic [7:0] sum;
`endif
   logic [3:0] rom_mem [8];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int base;
      int len;
      int stall_pct;
      int stall_first;
      bit mid_start;
      int exp_n;
      int exp_first;
   } vec_t;

   vec_t vecs [9];

   always #5 clk = ~clk;

   // The ROM: word[i] = 2*i, combinational read.
   assign rom_data = rom_mem[rom_addr[2:0]];

   rom_scan_reader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base      (base),
      .len       (len),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
`ifdef ROM_SCAN_SUM_EN
      ,
      .sum       (sum)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Run one scan and check every word against the address-window model.
   task automatic do_scan(input int b, input int l, input int stall_pct, input int stall_first,
                          input bit mid_start, output int nwords, output int first);
      int n, k, cyc, lat, stall_left, exp_sum, base_m, exp_addr;
      bit prev_stall, finished;
      int prev_data, prev_idx;
      n = (l > 8) ? 8 : l;
      base_m = b % 8;
      k = 0; cyc = 0; lat = -1; stall_left = stall_first; exp_sum = 0;
      prev_stall = 0; finished = 0; first = -1; prev_data = 0; prev_idx = 0;
      @(negedge clk);
      start = 1'b1; base = 8'(b); len = 4'(l); out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!finished && cyc < 300) begin
         cyc++;
         if (mid_start) start = (cyc == 3);
         if (out_valid && k == 0 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
         end
         if (out_valid) begin
            if (lat < 0) begin
               lat = cyc;
               chk("first_valid_latency", lat, 2);
            end
            if (prev_stall) begin
               chk("stall_data_stable", int'(out_data), prev_data);
               chk("stall_idx_stable", int'(out_idx), prev_idx);
            end
            if (out_ready) begin
               if (k >= n) begin
                  chk("word_beyond_scan", k, n - 1);
               end else begin
                  exp_addr = (base_m + k) % 8;
                  chk("word_data", int'(out_data), 2 * exp_addr);
                  chk("word_idx", int'(out_idx), k);
                  chk("word_rom_addr", int'(rom_addr), exp_addr);
                  if (k == 0) first = int'(out_data);
                  exp_sum += 2 * exp_addr;
               end
               k++;
            end
            prev_stall = !out_ready;
            prev_data  = int'(out_data);
            prev_idx   = int'(out_idx);
         end else begin
            prev_stall = 1'b0;
         end
         if (done) begin
            if (n == 0) chk("empty_done_latency", cyc, 1);
            chk("words_at_done", k, n);
            chk("busy_in_done", int'(busy), 1);
            chk("valid_in_done", int'(out_valid), 0);
`ifdef ROM_SCAN_SUM_EN
            chk("sum_in_done", int'(sum), exp_sum);
`endif
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
`ifdef ROM_SCAN_SUM_EN
            chk("sum_holds", int'(sum), exp_sum);
`endif
            finished = 1'b1;
         end
         if (!finished) @(negedge clk);
      end
      if (!finished) chk("scan_timeout", 0, 1);
      start = 1'b0;
      out_ready = 1'b1;
      nwords = k;
   endtask

   initial begin
      int nw, fw, b, l, i;
      for (int j = 0; j < 8; j++) rom_mem[j] = 4'(2 * j);
      rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_idx", int'(out_idx), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
`ifdef ROM_SCAN_SUM_EN
      chk("rst_sum", int'(sum), 0);
`endif
      rst_n = 1'b1;

      //            base len stall sf mid exp_n first
      vecs[0] = '{  0,   8,  0,   0, 0,  8,    0 };
      vecs[1] = '{  6,   4,  0,   0, 0,  4,   12 };
      vecs[2] = '{  3,   2,  0,   5, 0,  2,    6 };
      vecs[3] = '{  0,   0,  0,   0, 0,  0,   -1 };
      vecs[4] = '{  0,  12,  0,   0, 0,  8,    0 };
      vecs[5] = '{  5,   9, 40,   0, 1,  8,   10 };
      vecs[6] = '{200,   3,  0,   0, 1,  3,    0 };
      vecs[7] = '{ 13,   1,  0,   0, 0,  1,   10 };
      vecs[8] = '{  0,   8, 20,   0, 1,  8,    0 };
      for (int v = 0; v < 9; v++) begin
         do_scan(vecs[v].base, vecs[v].len, vecs[v].stall_pct, vecs[v].stall_first,
                 vecs[v].mid_start, nw, fw);
         chk("vec_nwords", nw, vecs[v].exp_n);
         chk("vec_first_word", fw, vecs[v].exp_first);
      end

      // Reset asserted while a word is held un-accepted.
      @(negedge clk);
      start = 1'b1; base = 8'd5; len = 4'd8; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      i = 0;
      while (i < 40 && !(out_valid && out_idx == 4'd2)) begin
         @(negedge clk);
         i++;
      end
      out_ready = 1'b0;
      chk("pre_reset_idx", int'(out_idx), 2);
      chk("pre_reset_data", int'(out_data), 14);
      chk("pre_reset_rom_addr", int'(rom_addr), 7);
      chk("pre_reset_busy", int'(busy), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_rom_addr", int'(rom_addr), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_out_idx", int'(out_idx), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      do_scan(2, 1, 0, 0, 0, nw, fw);
      chk("post_reset_nwords", nw, 1);
      chk("post_reset_word", fw, 4);

      // Randomized scans against the window model.
      for (int r = 0; r < 20; r++) begin
         b = int'($urandom_range(0, 255));
         l = int'($urandom_range(0, 15));
         do_scan(b, l, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), nw, fw);
         chk("rand_nwords", nw, (l > 8) ? 8 : l);
         if (l > 0) chk("rand_first_word", fw, 2 * (b % 8));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
